cp0_fwd_queue: RTL and testbench
================================

CP0_FWD_QUEUE -- requirements
Module: cp0_fwd_queue

Interface
REQ-001 SHALL have parameter ISSUE_NUM, default 2: write lanes per cycle; lane 0 is oldest in program order.
REQ-002 SHALL have parameter DEPTH, default 4: in-flight entries; power of two, >= ISSUE_NUM.
REQ-003 SHALL have parameter ADDR_W, default 8: CP0 address width, {reg[4:0], sel[2:0]}.
REQ-004 SHALL have port clk, input, 1: sole clock; all state updates on the rising edge.
REQ-005 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port wr_valid, input, ISSUE_NUM: per-lane CP0 write request.
REQ-007 SHALL have port wr_addr, input, ISSUE_NUM x ADDR_W: per-lane target register.
REQ-008 SHALL have port wr_data, input, ISSUE_NUM x 32: per-lane write data.
REQ-009 SHALL have port wr_mask, input, ISSUE_NUM x 32: per-lane writable-bit mask.
REQ-010 SHALL have port wr_ready, output, 1: the queue accepts a full ISSUE_NUM-lane group this cycle.
REQ-011 SHALL have port retire_cnt, input, clog2(ISSUE_NUM+1): number of oldest entries committed this cycle.
REQ-012 SHALL have port flush, input, 1: discard all entries.
REQ-013 SHALL have port rd_addr, input, ADDR_W: forwarding lookup address.
REQ-014 SHALL have port rd_cp0_data, input, 32: architectural CP0 value at rd_addr.
REQ-015 SHALL have port rd_data, output, 32: forwarded value.
REQ-016 SHALL have port rd_hit, output, 1: at least one entry or lane matched rd_addr.
REQ-017 SHALL have port count, output, clog2(DEPTH+1): occupancy.
REQ-018 SHALL have ports full and empty, output, 1 each: count==DEPTH and count==0.
REQ-019 SHALL have port err_underflow, output, 1: sticky retire-underflow flag.

Function
REQ-020 SHALL implement a circular FIFO with head/tail pointers wrapping modulo DEPTH.
REQ-021 SHALL assert wr_ready combinationally iff DEPTH-count >= ISSUE_NUM; same-cycle retires are not credited.
REQ-022 SHALL, on a rising edge with wr_ready=1 and flush=0, enqueue the valid lanes compacted in lane order, tail advancing by popcount(wr_valid).
REQ-023 SHALL ignore wr_valid while wr_ready=0; holding the request is the producer's responsibility.
REQ-024 SHALL dequeue min(retire_cnt, count) oldest entries per edge; the CP0 register file commits them on the same edge.
REQ-025 SHALL set err_underflow when retire_cnt > count at an edge, and still retire only count entries.
REQ-026 SHALL allow enqueue and retire on the same edge: count_next = count + enq - ret.
REQ-027 SHALL, when flush=1, set count, head and tail to 0 at that edge; flush overrides enqueue and retire, and err_underflow is not changed.
REQ-028 SHALL form rd_data by starting from rd_cp0_data and applying every matching entry from oldest to youngest as d = (d & ~mask) | (data & mask).
REQ-029 SHALL compute rd_data and rd_hit combinationally; an entry enqueued at edge N is visible from cycle N+1.
REQ-030 SHALL output rd_data = rd_cp0_data and rd_hit = 0 when nothing matches.

Reset
REQ-031 SHALL, while rst_n=0, force count=0, head=0, tail=0, err_underflow=0, empty=1, full=0 and wr_ready=1, independent of clk.
REQ-032 SHALL discard in-progress enqueues and retires when reset is asserted mid-operation; entry payload storage is not reset.

Configuration
REQ-033 SHALL provide macro CP0_FWD_BYPASS_EN.
REQ-034 SHALL, when CP0_FWD_BYPASS_EN is defined, also merge this cycle's valid, matching lanes as younger than all entries, lane 0 before lane 1, gated by wr_ready and !flush, and assert rd_hit for them.
REQ-035 SHALL, when CP0_FWD_BYPASS_EN is not defined, forward from queued entries only, with the one-cycle visibility of REQ-029.

Verification
REQ-036 SHALL check: reset, then enqueue lane0 {addr 0x60, data 0x1234, mask 0xFFFFFFFF} -> next cycle rd_addr=0x60 gives rd_data=0x1234, rd_hit=1, count=1.
REQ-037 SHALL check: rd_cp0_data=0xAAAA0000, queued entries {mask 0x0000FFFF, data 0x5555} then {mask 0xFF000000, data 0x11000000} -> rd_data=0x11AA5555.
REQ-038 SHALL check: DEPTH=4, ISSUE_NUM=2, count=3 -> wr_ready=0 and wr_valid ignored; retire_cnt=2 -> count=1 and wr_ready=1 the next cycle.
REQ-039 SHALL check: 10 cycles of enqueue-2/retire-2 at DEPTH=4 with distinct addresses -> pointers wrap, forwarded data correct, count stays 2.
REQ-040 SHALL check: flush together with wr_valid=2'b11 and retire_cnt=1 at count=2 -> count=0 and rd_hit=0 next cycle; retire_cnt=1 at count=0 -> err_underflow=1 held until reset.
REQ-041 SHALL check, with CP0_FWD_BYPASS_EN defined: empty queue and lane1 writing 0x60/0xBEEF with full mask -> rd_hit=1 and rd_data=0xBEEF in the same cycle.

Source files
------------

// File: rtl/cp0_fwd_queue.sv
`default_nettype none
// ============================================================================
//  Module   : cp0_fwd_queue
//  Brief    : In-flight CP0 write queue with read forwarding. Accepts up to
//             ISSUE_NUM writes per cycle (compacted in lane order), retires
//             the oldest entries on commit, and merges every matching entry
//             over the architectural CP0 value under its writable-bit mask.
//  Config   : `define CP0_FWD_BYPASS_EN to also forward this cycle's
//             accepted write lanes combinationally (youngest of all).
//  Revision : 1.0 - initial release
// ============================================================================
module cp0_fwd_queue #(
    parameter int ISSUE_NUM = 2,
    parameter int DEPTH     = 4,
    parameter int ADDR_W    = 8
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [ISSUE_NUM-1:0]            wr_valid,
    input  logic [ISSUE_NUM*ADDR_W-1:0]     wr_addr,
    input  logic [ISSUE_NUM*32-1:0]         wr_data,
    input  logic [ISSUE_NUM*32-1:0]         wr_mask,
    output logic                            wr_ready,
    input  logic [$clog2(ISSUE_NUM+1)-1:0]  retire_cnt,
    input  logic                            flush,
    input  logic [ADDR_W-1:0]               rd_addr,
    input  logic [31:0]                     rd_cp0_data,
    output logic [31:0]                     rd_data,
    output logic                            rd_hit,
    output logic [$clog2(DEPTH+1)-1:0]      count,
    output logic                            full,
    output logic                            empty,
    output logic                            err_underflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    // Entry payload (not reset: occupancy alone decides what is live)
    logic [ADDR_W-1:0] r_ent_addr [DEPTH];
    logic [31:0]       r_ent_data [DEPTH];
    logic [31:0]       r_ent_mask [DEPTH];

    logic [PTR_W-1:0]  r_head;
    logic [PTR_W-1:0]  r_tail;
    logic [CNT_W-1:0]  r_count;
    logic              r_err_underflow;

    logic [CNT_W-1:0]  w_free;
    logic              w_wr_ready;
    logic              w_enq_en;
    logic              w_byp_en;
    logic [CNT_W-1:0]  w_enq_cnt;
    logic [CNT_W-1:0]  w_enq_amt;
    logic [CNT_W-1:0]  w_ret_req;
    logic [CNT_W-1:0]  w_ret_cnt;
    logic              w_underflow;
    logic [PTR_W-1:0]  w_lane_off [ISSUE_NUM];
    logic [PTR_W-1:0]  w_lane_idx [ISSUE_NUM];
    logic [31:0]       w_rd_data;
    logic              w_rd_hit;

    // Admission: a whole group must fit; retires in the same cycle are not credited
    assign w_free     = CNT_W'(DEPTH) - r_count;
    assign w_wr_ready = (w_free >= CNT_W'(ISSUE_NUM));
    assign w_enq_en   = w_wr_ready && !flush;

`ifdef CP0_FWD_BYPASS_EN
    assign w_byp_en = w_enq_en;
`else
    assign w_byp_en = 1'b0;
`endif

    // Compaction: each valid lane lands after all older valid lanes
    always_comb begin
        w_enq_cnt = '0;
        for (int l = 0; l < ISSUE_NUM; l++) begin
            w_lane_off[l] = w_enq_cnt[PTR_W-1:0];
            w_lane_idx[l] = r_tail + w_enq_cnt[PTR_W-1:0];
            if (wr_valid[l]) begin
                w_enq_cnt = w_enq_cnt + CNT_W'(1);
            end
        end
    end

    assign w_enq_amt   = w_enq_en ? w_enq_cnt : '0;
    assign w_ret_req   = CNT_W'(retire_cnt);
    assign w_underflow = (w_ret_req > r_count);
    assign w_ret_cnt   = w_underflow ? r_count : w_ret_req;

    // Pointer/occupancy state; flush clears everything except the sticky error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head          <= '0;
            r_tail          <= '0;
            r_count         <= '0;
            r_err_underflow <= 1'b0;
        end else if (flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + w_ret_cnt[PTR_W-1:0];
            r_tail  <= r_tail + w_enq_amt[PTR_W-1:0];
            r_count <= r_count + w_enq_amt - w_ret_cnt;
            if (w_underflow) begin
                r_err_underflow <= 1'b1;
            end
        end
    end

    // Payload write: accepted valid lanes go to their compacted slots
    always_ff @(posedge clk) begin
        if (w_enq_en) begin
            for (int l = 0; l < ISSUE_NUM; l++) begin
                if (wr_valid[l]) begin
                    r_ent_addr[w_lane_idx[l]] <= wr_addr[l*ADDR_W +: ADDR_W];
                    r_ent_data[w_lane_idx[l]] <= wr_data[l*32 +: 32];
                    r_ent_mask[w_lane_idx[l]] <= wr_mask[l*32 +: 32];
                end
            end
        end
    end

    // Forwarding: merge live entries oldest-first, then (optionally) this cycle's lanes
    always_comb begin
        w_rd_data = rd_cp0_data;
        w_rd_hit  = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            if ((CNT_W'(k) < r_count) &&
                (r_ent_addr[r_head + PTR_W'(k)] == rd_addr)) begin
                w_rd_data = (w_rd_data & ~r_ent_mask[r_head + PTR_W'(k)]) |
                            (r_ent_data[r_head + PTR_W'(k)] & r_ent_mask[r_head + PTR_W'(k)]);
                w_rd_hit  = 1'b1;
            end
        end
        for (int l = 0; l < ISSUE_NUM; l++) begin
            if (w_byp_en && wr_valid[l] && (wr_addr[l*ADDR_W +: ADDR_W] == rd_addr)) begin
                w_rd_data = (w_rd_data & ~wr_mask[l*32 +: 32]) |
                            (wr_data[l*32 +: 32] & wr_mask[l*32 +: 32]);
                w_rd_hit  = 1'b1;
            end
        end
    end

    assign wr_ready      = w_wr_ready;
    assign rd_data       = w_rd_data;
    assign rd_hit        = w_rd_hit;
    assign count         = r_count;
    assign full          = (r_count == CNT_W'(DEPTH));
    assign empty         = (r_count == '0);
    assign err_underflow = r_err_underflow;

    // Unused lane offsets are kept for readability of the compaction logic
    logic w_unused_off;
    always_comb begin
        w_unused_off = 1'b0;
        for (int l = 0; l < ISSUE_NUM; l++) begin
            w_unused_off = w_unused_off ^ (^w_lane_off[l]);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cp0_fwd_queue.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cp0_fwd_queue
//  Brief    : Self-checking bench for cp0_fwd_queue. A queue-based reference
//             model produces expected outputs, pushed to a scoreboard when
//             stimulus is applied and popped when the outputs are sampled.
//             Honours `CP0_FWD_BYPASS_EN for same-cycle forwarding.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cp0_fwd_queue;

    localparam int ISSUE_NUM = 2;
    localparam int DEPTH     = 4;
    localparam int ADDR_W    = 8;

    logic        clk;
    logic        rst_n;
    logic [1:0]  wr_valid;
    logic [15:0] wr_addr;
    logic [63:0] wr_data;
    logic [63:0] wr_mask;
    logic        wr_ready;
    logic [1:0]  retire_cnt;
    logic        flush;
    logic [7:0]  rd_addr;
    logic [31:0] rd_cp0_data;
    logic [31:0] rd_data;
    logic        rd_hit;
    logic [2:0]  count;
    logic        full;
    logic        empty;
    logic        err_underflow;

    cp0_fwd_queue #(
        .ISSUE_NUM (ISSUE_NUM),
        .DEPTH     (DEPTH),
        .ADDR_W    (ADDR_W)
    ) u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .wr_valid      (wr_valid),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .wr_mask       (wr_mask),
        .wr_ready      (wr_ready),
        .retire_cnt    (retire_cnt),
        .flush         (flush),
        .rd_addr       (rd_addr),
        .rd_cp0_data   (rd_cp0_data),
        .rd_data       (rd_data),
        .rd_hit        (rd_hit),
        .count         (count),
        .full          (full),
        .empty         (empty),
        .err_underflow (err_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  a;
        logic [31:0] d;
        logic [31:0] m;
    } ent_t;

    typedef struct {
        logic [31:0] d;
        logic        h;
        int          cnt;
        logic        rdy;
        logic        full;
        logic        empty;
        logic        err;
    } exp_t;

    ent_t mq[$];
    exp_t sb[$];
    logic merr;
    int   n_total;
    int   n_bad;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%08h exp=0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected combinational outputs for the current inputs and model state
    function automatic exp_t model_expect();
        exp_t e;
        int   n;
        logic rdy;
        n   = mq.size();
        rdy = ((DEPTH - n) >= ISSUE_NUM);
        e.d = rd_cp0_data;
        e.h = 1'b0;
        foreach (mq[i]) begin
            if (mq[i].a == rd_addr) begin
                e.d = (e.d & ~mq[i].m) | (mq[i].d & mq[i].m);
                e.h = 1'b1;
            end
        end
`ifdef CP0_FWD_BYPASS_EN
        if (rdy && !flush) begin
            for (int l = 0; l < ISSUE_NUM; l++) begin
                if (wr_valid[l] && wr_addr[l*ADDR_W +: ADDR_W] == rd_addr) begin
                    e.d = (e.d & ~wr_mask[l*32 +: 32]) | (wr_data[l*32 +: 32] & wr_mask[l*32 +: 32]);
                    e.h = 1'b1;
                end
            end
        end
`endif
        e.cnt   = n;
        e.rdy   = rdy;
        e.full  = (n == DEPTH);
        e.empty = (n == 0);
        e.err   = merr;
        return e;
    endfunction

    // Reference state update at a rising edge
    task automatic model_step();
        int   n;
        int   r;
        logic rdy;
        ent_t t;
        n   = mq.size();
        rdy = ((DEPTH - n) >= ISSUE_NUM);
        if (flush) begin
            mq.delete();
        end else begin
            r = int'(retire_cnt);
            if (r > n) begin
                merr = 1'b1;
                r    = n;
            end
            for (int i = 0; i < r; i++) t = mq.pop_front();
            if (rdy) begin
                for (int l = 0; l < ISSUE_NUM; l++) begin
                    if (wr_valid[l]) begin
                        t.a = wr_addr[l*ADDR_W +: ADDR_W];
                        t.d = wr_data[l*32 +: 32];
                        t.m = wr_mask[l*32 +: 32];
                        mq.push_back(t);
                    end
                end
            end
        end
    endtask

    task automatic compare_out();
        exp_t e;
        if (sb.size() == 0) begin
            check_val("sb_underrun", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check_val("rd_data",  rd_data, e.d);
            check_val("rd_hit",   32'(rd_hit), 32'(e.h));
            check_val("count",    32'(count), 32'(e.cnt));
            check_val("wr_ready", 32'(wr_ready), 32'(e.rdy));
            check_val("full",     32'(full), 32'(e.full));
            check_val("empty",    32'(empty), 32'(e.empty));
            check_val("err",      32'(err_underflow), 32'(e.err));
        end
    endtask

    // Apply one cycle of stimulus (at posedge+1), then sample at negedge
    task automatic drive(input logic [1:0] v,
                         input logic [7:0] a0, input logic [31:0] d0, input logic [31:0] m0,
                         input logic [7:0] a1, input logic [31:0] d1, input logic [31:0] m1,
                         input logic [1:0] ret, input logic fl,
                         input logic [7:0] ra, input logic [31:0] cp0);
        wr_valid    = v;
        wr_addr     = {a1, a0};
        wr_data     = {d1, d0};
        wr_mask     = {m1, m0};
        retire_cnt  = ret;
        flush       = fl;
        rd_addr     = ra;
        rd_cp0_data = cp0;
        sb.push_back(model_expect());
        #4;
        compare_out();
    endtask

    task automatic idle(input logic [1:0] ret, input logic [7:0] ra, input logic [31:0] cp0);
        drive(2'b00, 8'h0, 32'h0, 32'h0, 8'h0, 32'h0, 32'h0, ret, 1'b0, ra, cp0);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_total     = 0;
        n_bad       = 0;
        merr        = 1'b0;
        rst_n       = 1'b0;
        wr_valid    = '0;
        wr_addr     = '0;
        wr_data     = '0;
        wr_mask     = '0;
        retire_cnt  = '0;
        flush       = 1'b0;
        rd_addr     = '0;
        rd_cp0_data = '0;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_count", 32'(count), 32'd0);
        check_val("rst_empty", 32'(empty), 32'd1);
        check_val("rst_full",  32'(full), 32'd0);
        check_val("rst_ready", 32'(wr_ready), 32'd1);
        check_val("rst_err",   32'(err_underflow), 32'd0);
        rst_n = 1'b1;

        // Single enqueue, visible next cycle
        drive(2'b01, 8'h60, 32'h1234, 32'hFFFF_FFFF, 8'h0, 32'h0, 32'h0, 2'd0, 1'b0, 8'h60, 32'h0);
        tick();
        idle(2'd0, 8'h60, 32'h0);
        check_val("fwd1_data",  rd_data, 32'h0000_1234);
        check_val("fwd1_hit",   32'(rd_hit), 32'd1);
        check_val("fwd1_count", 32'(count), 32'd1);
        tick();
        idle(2'd1, 8'h60, 32'h0);
        tick();

        // Two masked writes to one register in a single group, merged oldest first
        drive(2'b11, 8'h30, 32'h0000_5555, 32'h0000_FFFF, 8'h30, 32'h1100_0000, 32'hFF00_0000,
              2'd0, 1'b0, 8'h31, 32'h0);
        tick();
        idle(2'd0, 8'h30, 32'hAAAA_0000);
        check_val("merge_data", rd_data, 32'h11AA_5555);
        tick();
        idle(2'd2, 8'h30, 32'hAAAA_0000);
        tick();

        // Backpressure at count=3, then retire two
        drive(2'b11, 8'h40, 32'h40, 32'hFFFF_FFFF, 8'h41, 32'h41, 32'hFFFF_FFFF, 2'd0, 1'b0, 8'h40, 32'h0);
        tick();
        drive(2'b01, 8'h42, 32'h42, 32'hFFFF_FFFF, 8'h0, 32'h0, 32'h0, 2'd0, 1'b0, 8'h42, 32'h0);
        tick();
        drive(2'b11, 8'h43, 32'h43, 32'hFFFF_FFFF, 8'h44, 32'h44, 32'hFFFF_FFFF, 2'd0, 1'b0, 8'h43, 32'h0);
        check_val("bp_ready", 32'(wr_ready), 32'd0);
        tick();
        drive(2'b11, 8'h45, 32'h45, 32'hFFFF_FFFF, 8'h46, 32'h46, 32'hFFFF_FFFF, 2'd2, 1'b0, 8'h44, 32'h0);
        check_val("bp_count", 32'(count), 32'd3);
        tick();
        idle(2'd0, 8'h42, 32'h0);
        check_val("bp_after_count", 32'(count), 32'd1);
        check_val("bp_after_ready", 32'(wr_ready), 32'd1);
        tick();
        idle(2'd1, 8'h42, 32'h0);
        tick();

        // Steady enqueue-2 / retire-2 across pointer wraps
        drive(2'b11, 8'h10, 32'hD000_0010, 32'hFFFF_FFFF, 8'h11, 32'hD000_0011, 32'h0F0F_0F0F,
              2'd0, 1'b0, 8'h10, 32'h5A5A_5A5A);
        tick();
        for (int i = 0; i < 10; i++) begin
            drive(2'b11,
                  8'(8'h12 + 2*i), 32'hD000_0000 + 32'(2*i + 2), 32'hFFFF_FFFF,
                  8'(8'h13 + 2*i), 32'hE000_0000 + 32'(2*i + 3), 32'h00FF_00FF,
                  2'd2, 1'b0, 8'(8'h11 + 2*i), 32'h5A5A_5A5A);
            tick();
        end
        idle(2'd0, 8'h25, 32'h5A5A_5A5A);
        check_val("wrap_count", 32'(count), 32'd2);
        tick();

        // Flush overrides enqueue and retire; underflow is sticky
        drive(2'b11, 8'h70, 32'h70, 32'hFFFF_FFFF, 8'h71, 32'h71, 32'hFFFF_FFFF, 2'd1, 1'b1, 8'h25, 32'hCAFE);
        tick();
        idle(2'd0, 8'h25, 32'hCAFE);
        check_val("flush_count", 32'(count), 32'd0);
        check_val("flush_hit",   32'(rd_hit), 32'd0);
        tick();
        idle(2'd1, 8'h25, 32'hCAFE);
        tick();
        idle(2'd0, 8'h25, 32'hCAFE);
        check_val("uflow_err", 32'(err_underflow), 32'd1);
        tick();
        repeat (3) begin
            idle(2'd0, 8'h0, 32'h0);
            tick();
        end
        drive(2'b00, 8'h0, 32'h0, 32'h0, 8'h0, 32'h0, 32'h0, 2'd0, 1'b1, 8'h0, 32'h0);
        tick();
        idle(2'd0, 8'h0, 32'h0);
        check_val("uflow_held", 32'(err_underflow), 32'd1);
        tick();

        // Randomised traffic over a small address set
        for (int i = 0; i < 40; i++) begin
            drive(2'($urandom_range(0, 3)),
                  8'(8'h20 + $urandom_range(0, 3)), $urandom, $urandom,
                  8'(8'h20 + $urandom_range(0, 3)), $urandom, $urandom,
                  2'($urandom_range(0, 3)), ($urandom_range(0, 15) == 0),
                  8'(8'h20 + $urandom_range(0, 3)), $urandom);
            tick();
        end

        // Asynchronous reset in the middle of traffic
        drive(2'b11, 8'h50, 32'h50, 32'hFFFF_FFFF, 8'h51, 32'h51, 32'hFFFF_FFFF, 2'd0, 1'b0, 8'h50, 32'h0);
        tick();
        wr_valid   = 2'b11;
        retire_cnt = 2'd0;
        flush      = 1'b0;
        rd_addr    = 8'h50;
        #1;
        rst_n = 1'b0;
        #1;
        check_val("arst_count", 32'(count), 32'd0);
        check_val("arst_empty", 32'(empty), 32'd1);
        check_val("arst_full",  32'(full), 32'd0);
        check_val("arst_ready", 32'(wr_ready), 32'd1);
        check_val("arst_err",   32'(err_underflow), 32'd0);
        mq.delete();
        merr = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Same-cycle lane forwarding (only when bypass is built in)
        drive(2'b10, 8'h0, 32'h0, 32'h0, 8'h60, 32'hBEEF, 32'hFFFF_FFFF, 2'd0, 1'b0, 8'h60, 32'h0);
`ifdef CP0_FWD_BYPASS_EN
        check_val("byp_hit",  32'(rd_hit), 32'd1);
        check_val("byp_data", rd_data, 32'h0000_BEEF);
`else
        check_val("byp_hit",  32'(rd_hit), 32'd0);
        check_val("byp_data", rd_data, 32'h0);
`endif
        tick();
        idle(2'd0, 8'h60, 32'h0);
        check_val("byp_next_data", rd_data, 32'h0000_BEEF);
        tick();
        drive(2'b01, 8'h61, 32'h61, 32'hFFFF_FFFF, 8'h0, 32'h0, 32'h0, 2'd0, 1'b1, 8'h61, 32'h0);
        check_val("byp_flush_hit", 32'(rd_hit), 32'd0);
        tick();

        check_val("sb_drain", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
